// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the 32x32 MIPS register file: tracks in-flight
// destinations, generates the issue stall and caps outstanding writes.
module regfile_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IssueValid,
   input  logic [4:0]       IssueRs,
   input  logic [4:0]       IssueRt,
   input  logic             IssueUseRs,
   input  logic             IssueUseRt,
   input  logic             IssueWrites,
   input  logic [4:0]       IssueRd,
   input  logic             WbValid,
   input  logic [4:0]       WbRd,
   input  logic             Flush,
   output logic             Stall,
   output logic             IssueAccept,
   output logic [31:0]      PendingMask,
   output logic [CNT_W-1:0] PendingCount,
   output logic             Error
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   logic [31:0]      r_mask;
   logic [CNT_W-1:0] r_count;
   logic             r_error;

   logic             w_wb_hit;
   logic             w_wb_clr;
   logic             w_wb_err;
   logic [31:0]      w_clr_vec;
   logic [31:0]      w_set_vec;
   logic [31:0]      w_eff;
   logic             w_rd_real;
   logic             w_raw;
   logic             w_waw;
   logic             w_full;
   logic             w_stall;
   logic             w_accept;
   logic             w_set;
   logic [CNT_W-1:0] w_count_wb;
   logic [31:0]      w_mask_next;
   logic [CNT_W-1:0] w_count_next;

   // Register 0 is never tracked, so both indices are qualified against zero.
   assign w_wb_hit  = WbValid & (WbRd != 5'd0);
   assign w_wb_clr  = w_wb_hit & r_mask[WbRd];
   assign w_wb_err  = w_wb_hit & ~r_mask[WbRd];
   assign w_rd_real = IssueWrites & (IssueRd != 5'd0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_clr_vec = '0;
      w_set_vec = '0;
      if (w_wb_clr) w_clr_vec[WbRd] = 1'b1;
      if (w_set)    w_set_vec[IssueRd] = 1'b1;
   end

   // The writeback releases its register in the same cycle: the register file
   // writes on posedge and reads on negedge, so the consumer sees fresh data.
   assign w_eff = r_mask & ~w_clr_vec;

   assign w_raw = (IssueUseRs & w_eff[IssueRs]) | (IssueUseRt & w_eff[IssueRt]);
   assign w_waw = w_rd_real & w_eff[IssueRd];

   // w_wb_clr implies r_count >= 1, so the subtraction never underflows.
   assign w_count_wb = r_count - CNT_W'(w_wb_clr);
   assign w_full     = w_rd_real & (w_count_wb >= MAX_CNT);

   assign w_stall  = IssueValid & (w_raw | w_waw | w_full);
   assign w_accept = IssueValid & ~w_stall & ~Flush;
   assign w_set    = w_accept & w_rd_real;

   // Set wins over a same-cycle clear of the same register; the count nets to zero.
   assign w_mask_next  = (r_mask & ~w_clr_vec) | w_set_vec;
   assign w_count_next = w_count_wb + CNT_W'(w_set);

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (Reset) begin
         r_mask  <= '0;
         r_count <= '0;
         r_error <= 1'b0;
      end else if (Flush) begin
         r_mask  <= '0;
         r_count <= '0;
      end else begin
         r_mask  <= w_mask_next;
         r_count <= w_count_next;
         if (w_wb_err) r_error <= 1'b1;
      end
   end

   assign Stall        = w_stall;
   assign IssueAccept  = w_accept;
   assign PendingMask  = r_mask;
   assign PendingCount = r_count;
   assign Error        = r_error;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_regfile_scoreboard;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IssueValid;
   logic [4:0]  IssueRs;
   logic [4:0]  IssueRt;
   logic        IssueUseRs;
   logic        IssueUseRt;
   logic        IssueWrites;
   logic [4:0]  IssueRd;
   logic        WbValid;
   logic [4:0]  WbRd;
   logic        Flush;
   logic        Stall;
   logic        IssueAccept;
   logic [31:0] PendingMask;
   logic [5:0]  PendingCount;
   logic        Error;

   int checks   = 0;
   int failures = 0;

   regfile_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(6)) dut (
      .Clk(Clk), .Reset(Reset),
      .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
      .IssueUseRs(IssueUseRs), .IssueUseRt(IssueUseRt),
      .IssueWrites(IssueWrites), .IssueRd(IssueRd),
      .WbValid(WbValid), .WbRd(WbRd), .Flush(Flush),
      .Stall(Stall), .IssueAccept(IssueAccept),
      .PendingMask(PendingMask), .PendingCount(PendingCount), .Error(Error)
   );

   always #5 Clk = ~Clk;

   // Advance past the next posedge; inputs are then driven and outputs sampled well before the following edge.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Reset = 1'b0; IssueValid = 1'b0; IssueRs = 5'd0; IssueRt = 5'd0;
      IssueUseRs = 1'b0; IssueUseRt = 1'b0; IssueWrites = 1'b0; IssueRd = 5'd0;
      WbValid = 1'b0; WbRd = 5'd0; Flush = 1'b0;
   endtask

   task automatic drive_write(input logic [4:0] rd);
      idle();
      IssueValid = 1'b1; IssueWrites = 1'b1; IssueRd = rd;
   endtask

   task automatic drive_wb(input logic [4:0] rd);
      idle();
      WbValid = 1'b1; WbRd = rd;
   endtask

   task automatic test_reset();
      idle();
      Reset = 1'b1;
      step();
      step();
      idle();
      #1;
      checks++; if (PendingMask !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=%h", PendingMask, 32'h0); end
      checks++; if (PendingCount !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", PendingCount); end
      checks++; if (Error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", Error); end
      checks++; if (Stall !== 1'b0 || IssueAccept !== 1'b0) begin failures++; $display("FAIL reset_idle stall=%b accept=%b exp=0/0", Stall, IssueAccept); end
   endtask

   task automatic test_first_issue();
      drive_write(5'd8);
      #1;
      checks++; if (IssueAccept !== 1'b1 || Stall !== 1'b0) begin failures++; $display("FAIL first_accept accept=%b stall=%b exp=1/0", IssueAccept, Stall); end
      step();
      idle();
      checks++; if (PendingMask !== 32'h0000_0100) begin failures++; $display("FAIL first_mask got=%h exp=%h", PendingMask, 32'h100); end
      checks++; if (PendingCount !== 6'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", PendingCount); end
   endtask

   task automatic test_raw();
      idle();
      IssueValid = 1'b1; IssueUseRs = 1'b1; IssueRs = 5'd8;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (Stall !== 1'b1 || IssueAccept !== 1'b0) begin failures++; $display("FAIL raw_hold cyc=%0d stall=%b accept=%b exp=1/0", i, Stall, IssueAccept); end
         step();
      end
      // Rt path: same hazard seen through the second source.
      IssueUseRs = 1'b0; IssueUseRt = 1'b1; IssueRt = 5'd8;
      #1;
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL raw_rt stall=%b exp=1", Stall); end
      WbValid = 1'b1; WbRd = 5'd8;
      #1;
      checks++; if (Stall !== 1'b0 || IssueAccept !== 1'b1) begin failures++; $display("FAIL raw_bypass stall=%b accept=%b exp=0/1", Stall, IssueAccept); end
      step();
      idle();
      checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0) begin failures++; $display("FAIL raw_release mask=%h count=%0d exp=0/0", PendingMask, PendingCount); end
      checks++; if (Error !== 1'b0) begin failures++; $display("FAIL raw_error got=%b exp=0", Error); end
   endtask

   task automatic test_full();
      for (int r = 1; r <= 4; r++) begin
         drive_write(5'(r));
         #1;
         checks++; if (IssueAccept !== 1'b1) begin failures++; $display("FAIL full_fill rd=%0d accept=%b exp=1", r, IssueAccept); end
         step();
      end
      idle();
      checks++; if (PendingMask !== 32'h0000_001E || PendingCount !== 6'd4) begin failures++; $display("FAIL full_state mask=%h count=%0d exp=0000001e/4", PendingMask, PendingCount); end
      drive_write(5'd5);
      #1;
      checks++; if (Stall !== 1'b1 || IssueAccept !== 1'b0) begin failures++; $display("FAIL full_stall stall=%b accept=%b exp=1/0", Stall, IssueAccept); end
      // A non-writing instruction is never blocked by the cap.
      IssueWrites = 1'b0; IssueUseRs = 1'b1; IssueRs = 5'd9;
      #1;
      checks++; if (Stall !== 1'b0 || IssueAccept !== 1'b1) begin failures++; $display("FAIL full_nowrite stall=%b accept=%b exp=0/1", Stall, IssueAccept); end
      drive_write(5'd5);
      WbValid = 1'b1; WbRd = 5'd2;
      #1;
      checks++; if (Stall !== 1'b0 || IssueAccept !== 1'b1) begin failures++; $display("FAIL full_wb_free stall=%b accept=%b exp=0/1", Stall, IssueAccept); end
      step();
      idle();
      checks++; if (PendingMask !== 32'h0000_003A || PendingCount !== 6'd4) begin failures++; $display("FAIL full_swap mask=%h count=%0d exp=0000003a/4", PendingMask, PendingCount); end
      // WAW: rewriting a pending destination stalls.
      drive_write(5'd3);
      #1;
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL full_waw stall=%b exp=1", Stall); end
      drive_wb(5'd1); step();
      drive_wb(5'd3); step();
      drive_wb(5'd4); step();
      drive_wb(5'd5); step();
      idle();
      checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0 || Error !== 1'b0) begin failures++; $display("FAIL full_drain mask=%h count=%0d err=%b exp=0/0/0", PendingMask, PendingCount, Error); end
   endtask

   task automatic test_set_clear();
      drive_write(5'd3);
      step();
      idle();
      checks++; if (PendingMask !== 32'h0000_0008 || PendingCount !== 6'd1) begin failures++; $display("FAIL sc_setup mask=%h count=%0d exp=00000008/1", PendingMask, PendingCount); end
      drive_write(5'd3);
      WbValid = 1'b1; WbRd = 5'd3;
      #1;
      checks++; if (IssueAccept !== 1'b1) begin failures++; $display("FAIL sc_accept accept=%b exp=1", IssueAccept); end
      step();
      idle();
      checks++; if (PendingMask !== 32'h0000_0008 || PendingCount !== 6'd1) begin failures++; $display("FAIL sc_set_wins mask=%h count=%0d exp=00000008/1", PendingMask, PendingCount); end
      drive_wb(5'd3);
      step();
      idle();
      checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0) begin failures++; $display("FAIL sc_drain mask=%h count=%0d exp=0/0", PendingMask, PendingCount); end
   endtask

   task automatic test_flush();
      for (int r = 12; r <= 15; r++) begin
         drive_write(5'(r));
         step();
      end
      idle();
      checks++; if (PendingMask !== 32'h0000_F000 || PendingCount !== 6'd4) begin failures++; $display("FAIL flush_setup mask=%h count=%0d exp=0000f000/4", PendingMask, PendingCount); end
      IssueValid = 1'b1; IssueUseRs = 1'b1; IssueRs = 5'd1; Flush = 1'b1;
      #1;
      checks++; if (IssueAccept !== 1'b0 || Stall !== 1'b0) begin failures++; $display("FAIL flush_accept accept=%b stall=%b exp=0/0", IssueAccept, Stall); end
      IssueRs = 5'd12;
      #1;
      checks++; if (Stall !== 1'b1 || IssueAccept !== 1'b0) begin failures++; $display("FAIL flush_stall stall=%b accept=%b exp=1/0", Stall, IssueAccept); end
      // Writeback to a non-pending register during flush must not flag an error.
      WbValid = 1'b1; WbRd = 5'd20;
      step();
      idle();
      checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0) begin failures++; $display("FAIL flush_clear mask=%h count=%0d exp=0/0", PendingMask, PendingCount); end
      checks++; if (Error !== 1'b0) begin failures++; $display("FAIL flush_error got=%b exp=0", Error); end
   endtask

   task automatic test_reg0_error();
      for (int i = 0; i < 3; i++) begin
         drive_write(5'd0);
         IssueUseRs = 1'b1; IssueRs = 5'd0;
         WbValid = 1'b1; WbRd = 5'd0;
         #1;
         checks++; if (Stall !== 1'b0 || IssueAccept !== 1'b1) begin failures++; $display("FAIL r0_issue cyc=%0d stall=%b accept=%b exp=0/1", i, Stall, IssueAccept); end
         step();
         checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0 || Error !== 1'b0) begin failures++; $display("FAIL r0_state cyc=%0d mask=%h count=%0d err=%b exp=0/0/0", i, PendingMask, PendingCount, Error); end
      end
      drive_wb(5'd9);
      step();
      idle();
      checks++; if (Error !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", Error); end
      step(); step(); step();
      checks++; if (Error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", Error); end
   endtask

   task automatic test_reset_mid();
      drive_write(5'd7);
      step();
      drive_write(5'd10);
      step();
      idle();
      checks++; if (PendingMask !== 32'h0000_0480 || PendingCount !== 6'd2 || Error !== 1'b1) begin failures++; $display("FAIL rst_setup mask=%h count=%0d err=%b exp=00000480/2/1", PendingMask, PendingCount, Error); end
      drive_write(5'd11);
      WbValid = 1'b1; WbRd = 5'd25;
      Reset = 1'b1;
      step();
      idle();
      checks++; if (PendingMask !== 32'h0 || PendingCount !== 6'd0 || Error !== 1'b0) begin failures++; $display("FAIL rst_mid mask=%h count=%0d err=%b exp=0/0/0", PendingMask, PendingCount, Error); end
   endtask

   initial begin
      idle();
      test_reset();
      test_first_issue();
      test_raw();
      test_full();
      test_set_clear();
      test_flush();
      test_reg0_error();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks in-flight destination registers for the 32x32 MIPS register file and generates the issue stall.
- Each accepted instruction that writes a register marks that register pending. A writeback clears the mark. An instruction whose sources or destination are pending is held at issue.
- Sits between decode/issue and the register file write port. Also caps the number of outstanding writes.

Parameters:
- MAX_INFLIGHT, 4, maximum simultaneously pending destination registers (1..31).
- CNT_W, 6, width of PendingCount; must hold 31.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- IssueValid  in  1  instruction presented at issue this cycle.
- IssueRs  in  5  source register 1 index.
- IssueRt  in  5  source register 2 index.
- IssueUseRs  in  1  instruction reads Rs.
- IssueUseRt  in  1  instruction reads Rt.
- IssueWrites  in  1  instruction writes a register.
- IssueRd  in  5  destination register index.
- WbValid  in  1  register file write occurring this cycle (RegWrite).
- WbRd  in  5  register index being written (WriteRegister).
- Flush  in  1  discard all outstanding writes.
- Stall  out  1  combinational; hold the issue stage.
- IssueAccept  out  1  combinational; IssueValid & ~Stall & ~Flush.
- PendingMask  out  32  registered pending bit per register; bit 0 always 0.
- PendingCount  out  CNT_W  registered popcount of PendingMask.
- Error  out  1  registered sticky flag: writeback to a non-pending register.

Behaviour:
- Reset (synchronous, any cycle, including mid-operation): PendingMask=0, PendingCount=0, Error=0. Reset overrides Flush, issue and writeback in the same cycle.
- Register 0:
  - Never pending.
  - IssueWrites with IssueRd=0 is treated as non-writing.
  - WbValid with WbRd=0 is ignored and does not set Error.
- Effective pending (combinational): eff[r] = PendingMask[r] & ~(WbValid & WbRd==r & r!=0).
  - A writeback releases its register in the same cycle, because the register file writes on posedge and reads on negedge.
- Stall = IssueValid & (RAW | WAW | FULL), where:
  - RAW = (IssueUseRs & eff[IssueRs]) | (IssueUseRt & eff[IssueRt]).
  - WAW = IssueWrites & IssueRd!=0 & eff[IssueRd].
  - FULL = IssueWrites & IssueRd!=0 & (PendingCount - wbclr) >= MAX_INFLIGHT, where wbclr = 1 when a valid writeback clears a set bit this cycle.
- Stall is 0 whenever IssueValid=0.
- Flush (without Reset):
  - Next PendingMask=0 and PendingCount=0; Error is unchanged.
  - IssueAccept is forced to 0 and Stall is unaffected.
  - Any writeback in the same cycle is dropped and does not set Error.
- Posedge update (no Reset, no Flush):
  - Clear: WbValid & WbRd!=0 & PendingMask[WbRd] clears that bit.
  - Error: WbValid & WbRd!=0 & ~PendingMask[WbRd] sets Error (sticky until Reset).
  - Set: IssueAccept & IssueWrites & IssueRd!=0 sets bit IssueRd.
  - Same-cycle set and clear of the same register: set wins; the bit stays 1 and the count is net unchanged.
  - PendingCount_next = PendingCount + set - clear. It is never above MAX_INFLIGHT and never wraps.
- Latency: Stall and IssueAccept are 0-cycle (combinational). PendingMask, PendingCount and Error update 1 cycle after the event.
- No internal FSM beyond the mask/counter. Implementation cost is dominated by the 32-entry decode/compare and update logic.

Test Plan:
- Reset, then issue Rd=8 (IssueWrites=1), no writeback -> IssueAccept=1; next cycle PendingMask=0x00000100, PendingCount=1.
- With $8 pending, issue IssueRs=8 IssueUseRs=1 -> Stall=1 and IssueAccept=0 every cycle. On the cycle with WbValid=1 WbRd=8 -> Stall=0 and IssueAccept=1 in that same cycle; next cycle mask bit 8 is 0.
- MAX_INFLIGHT=4: accept writes to $1..$4, count=4; issue Rd=5 -> Stall=1. Same cycle plus WbRd=2 -> Stall=0 and accept; next cycle count stays 4, mask=0x0000003A.
- Issue Rd=0 and WbRd=0 repeatedly -> Stall=0, mask and count remain 0, Error remains 0. WbValid=1 WbRd=9 with $9 not pending -> Error=1 next cycle and stays 1 until Reset.
- $3 pending; same cycle WbRd=3 and accepted issue Rd=3 -> next cycle bit 3 = 1, count unchanged.
- Mask=0x0000F000, count=4: assert Flush with IssueValid=1 -> IssueAccept=0; next cycle mask=0 and count=0. Then Reset with pending bits and Error=1 -> all outputs 0 next cycle.
